// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meter
//  Purpose  : Gated frequency counter. Counts rising edges of an asynchronous
//             input over a fixed gate of GateCycles clocks and publishes the
//             count with a one-cycle Valid strobe. Back-to-back gates run
//             with no dead cycle while En stays high.
//  Ports    : Clk   - system clock (rising edge)
//             Rst   - synchronous active-high reset
//             En    - measurement enable (level)
//             SigIn - asynchronous signal being measured
//             Freq  - edge count of the last completed gate (registered)
//             Valid - one-cycle pulse when Freq/Ovf are updated
//             Ovf   - last completed gate lost edges to counter saturation
//             Busy  - a gate is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module freq_meter #(
  parameter int BoardFreq  = 50_000_000,
  parameter int GateCycles = BoardFreq,
  parameter int GateBits   = 27,
  parameter int CntBits    = 27
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En,
  input  logic               SigIn,
  output logic [CntBits-1:0] Freq,
  output logic               Valid,
  output logic               Ovf,
  output logic               Busy
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [GateBits-1:0] GateLast = GateBits'(GateCycles - 1);
  localparam logic [GateBits-1:0] GateOne  = GateBits'(1);
  localparam logic [CntBits-1:0]  CntMax   = '1;
  localparam logic [CntBits-1:0]  CntOne   = CntBits'(1);

  state_t               state_q, state_d;
  logic [2:0]           sync_q, sync_d;      // [0],[1] synchronizer, [2] delay
  logic [GateBits-1:0]  gate_cnt_q, gate_cnt_d;
  logic [CntBits-1:0]   edge_cnt_q, edge_cnt_d;
  logic                 sat_q, sat_d;        // an edge was dropped this gate
  logic [CntBits-1:0]   freq_q, freq_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;

  logic                 detect;
  logic                 at_max;
  logic                 lost;
  logic                 terminal;
  logic [CntBits-1:0]   edge_next;

  always_comb begin
    sync_d     = {sync_q[1:0], SigIn};
    detect     = sync_q[1] & ~sync_q[2];
    at_max     = (edge_cnt_q == CntMax);
    // Ovf means the count is a lower bound: an edge arrived while full.
    lost       = detect & at_max;
    edge_next  = (detect && !at_max) ? (edge_cnt_q + CntOne) : edge_cnt_q;
    terminal   = (state_q == MEASURE) && (gate_cnt_q == GateLast);

    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (En) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (terminal) begin
          // The detect pulse of the terminal cycle belongs to this gate;
          // the next gate starts from zero in the following cycle.
          freq_d     = edge_next;
          ovf_d      = sat_q | lost;
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          state_d    = En ? MEASURE : IDLE;
        end else if (!En) begin
          // Abort: results keep their previous values, counters are
          // cleared on the way back through IDLE.
          state_d = IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + GateOne;
          edge_cnt_d = edge_next;
          sat_d      = sat_q | lost;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign Freq  = freq_q;
  assign Ovf   = ovf_q;
  assign Valid = valid_q;
  assign Busy  = (state_q == MEASURE);

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_meter
//  Purpose  : Self-checking bench for freq_meter (GateCycles=100, CntBits=4).
//             The reference model tracks gate windows as ranges of sampled
//             SigIn values and counts rising transitions inside each window.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int G    = 100;
  localparam int CB   = 4;
  localparam int MAXC = 20000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          sig = 1'b0;
  logic [CB-1:0] freq;
  logic          valid;
  logic          ovf;
  logic          busy;

  freq_meter #(
    .BoardFreq (1000),
    .GateCycles(G),
    .GateBits  (7),
    .CntBits   (CB)
  ) dut (
    .Clk  (clk),
    .Rst  (rst),
    .En   (en),
    .SigIn(sig),
    .Freq (freq),
    .Valid(valid),
    .Ovf  (ovf),
    .Busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // Per-edge history and expectations, indexed by edge number.
  bit          s_hist    [MAXC];
  bit          exp_busy  [MAXC];
  bit          exp_valid [MAXC];
  logic [CB-1:0] exp_freq[MAXC];
  bit          exp_ovf   [MAXC];

  typedef struct {
    logic [CB-1:0] f;
    bit            o;
  } res_t;
  res_t sb_q[$];

  bit            m_meas = 1'b0;
  int            m_t0   = 0;
  logic [CB-1:0] m_freq = '0;
  bit            m_ovf  = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc - 1, act, exp);
    end
  endtask

  // A gate that starts at edge t0 counts rising transitions of the sampled
  // SigIn stream at sample indices t0-1 .. t0+G-2 (two synchronizer stages)
  // and finishes at edge t0+G.
  task automatic model_step(input int k, input bit r, input bit e, input bit sg);
    bit v;
    int n;
    v = 1'b0;
    s_hist[k] = r ? 1'b0 : sg;
    if (r) begin
      m_meas = 1'b0;
      m_freq = '0;
      m_ovf  = 1'b0;
    end else if (!m_meas) begin
      if (e) begin
        m_meas = 1'b1;
        m_t0   = k;
      end
    end else if (k == m_t0 + G) begin
      n = 0;
      for (int j = m_t0 - 1; j <= m_t0 + G - 2; j++) begin
        if (s_hist[j] && !((j > 0) ? s_hist[j-1] : 1'b0)) n++;
      end
      m_freq = (n > 15) ? 4'd15 : 4'(n);
      m_ovf  = (n > 15);
      sb_q.push_back('{f: m_freq, o: m_ovf});
      v = 1'b1;
      if (e) m_t0 = k;
      else   m_meas = 1'b0;
    end else if (!e) begin
      m_meas = 1'b0;
    end
    exp_busy[k]  = m_meas;
    exp_valid[k] = v;
    exp_freq[k]  = m_freq;
    exp_ovf[k]   = m_ovf;
  endtask

  task automatic drive(input bit r, input bit e, input bit sg);
    if (cyc < MAXC) begin
      rst = r;
      en  = e;
      sig = sg;
      model_step(cyc, r, e, sg);
    end
    @(negedge clk);
  endtask

  function automatic bit sq(input int k, input int per, input int ph);
    return ((k + ph) % per) < (per / 2);
  endfunction

  // Monitor: checks every edge's outputs and pops the scoreboard on Valid.
  initial begin
    int n;
    res_t r;
    forever begin
      @(posedge clk);
      #1;
      n = cyc - 1;
      if (n >= 0 && n < MAXC) begin
        check("valid", int'(valid), int'(exp_valid[n]));
        check("busy",  int'(busy),  int'(exp_busy[n]));
        check("freq_hold", int'(freq), int'(exp_freq[n]));
        check("ovf_hold",  int'(ovf),  int'(exp_ovf[n]));
        if (valid || exp_valid[n]) begin
          if (sb_q.size() == 0) begin
            check("sb_empty_on_valid", 1, 0);
          end else begin
            r = sb_q.pop_front();
            if (valid) begin
              check("sb_freq", int'(freq), int'(r.f));
              check("sb_ovf",  int'(ovf),  int'(r.o));
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    int per;
    int mode;
    // Reset for two edges, then idle with En low.
    drive(1, 0, 0);
    drive(1, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0);

    // Continuous gates, period-10 signal.
    for (int i = 0; i < 310; i++) drive(0, 1, sq(cyc, 10, 7));
    // Constant low, then constant high.
    for (int i = 0; i < 200; i++) drive(0, 1, 1'b0);
    for (int i = 0; i < 200; i++) drive(0, 1, 1'b1);
    // Toggle every clock: 50 edges per gate saturates a 4-bit counter.
    for (int i = 0; i < 210; i++) drive(0, 1, sq(cyc, 2, 0));
    for (int i = 0; i < 200; i++) drive(0, 1, sq(cyc, 10, 3));

    // Abort at gate cycle 50, then restart.
    guard = 0;
    while (!(m_meas && cyc == m_t0 + 51) && guard < 300) begin
      drive(0, 1, sq(cyc, 10, 3));
      guard++;
    end
    check("abort_reached", int'(guard < 300), 1);
    for (int i = 0; i < 3; i++) drive(0, 0, sq(cyc, 10, 3));
    for (int i = 0; i < 220; i++) drive(0, 1, sq(cyc, 10, 3));

    // Reset exactly on a terminal edge.
    guard = 0;
    while (!(m_meas && cyc == m_t0 + G) && guard < 300) begin
      drive(0, 1, sq(cyc, 10, 1));
      guard++;
    end
    check("terminal_reached", int'(guard < 300), 1);
    drive(1, 1, sq(cyc, 10, 1));
    for (int i = 0; i < 20; i++) drive(0, 0, sq(cyc, 10, 1));

    // Randomized traffic: varying periods, noise, En drops, rare resets.
    per  = 10;
    mode = 1;
    for (int i = 0; i < 5000; i++) begin
      if (i % 250 == 0) begin
        per  = $urandom_range(2, 40);
        mode = $urandom_range(0, 3);
      end
      drive(($urandom_range(0, 1499) == 0),
            ($urandom_range(0, 299) != 0),
            (mode == 0) ? ($urandom_range(0, 1) == 1) : sq(cyc, per, 0));
    end
    for (int i = 0; i < 5; i++) drive(0, 0, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
